dmem_cache_wb: RTL and testbench



---
 rtl/dmem_cache_pkg.sv | 29 ++
 rtl/dmem_cache_wb_rr_arbiter.sv | 30 +++
 rtl/dmem_cache_wb.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_cache_wb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_cache_pkg.sv
// Shared state encodings and address-field helpers for the write-back data cache.
package dmem_cache_pkg;

  localparam int unsigned STATE_BITS = 3;

  localparam logic [STATE_BITS-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_BITS-1:0] S_LOOKUP = 3'd1;
  localparam logic [STATE_BITS-1:0] S_EVICT  = 3'd2;
  localparam logic [STATE_BITS-1:0] S_FILL   = 3'd3;
  localparam logic [STATE_BITS-1:0] S_RELAY  = 3'd4;

  // Helpers work on a zero-extended address word; callers cast the result to field width.
  typedef logic [31:0] addr_word_t;

  function automatic addr_word_t get_offset(addr_word_t addr, int unsigned offset_bits);
    return addr & ((addr_word_t'(1) << offset_bits) - addr_word_t'(1));
  endfunction

  function automatic addr_word_t get_index(addr_word_t addr, int unsigned offset_bits,
                                           int unsigned index_bits);
    return (addr >> offset_bits) & ((addr_word_t'(1) << index_bits) - addr_word_t'(1));
  endfunction

  function automatic addr_word_t get_tag(addr_word_t addr, int unsigned offset_bits,
                                         int unsigned index_bits);
    return addr >> (offset_bits + index_bits);
  endfunction

endpackage

// File: rtl/dmem_cache_wb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_c_o,
  output logic [IDX_W-1:0]   gnt_idx_c_o,
  output logic               gnt_vld_c_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh_c_o  = '0;
    gnt_idx_c_o = '0;
    gnt_vld_c_o = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!gnt_vld_c_o && req_i[cand]) begin
        gnt_vld_c_o      = 1'b1;
        gnt_idx_c_o      = cand;
        gnt_oh_c_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_cache_wb.sv
// Direct-mapped write-back/write-allocate data cache, one request in flight, RR-granted consumers.
// Optional build macro DMEM_CACHE_PERF_COUNTERS_EN adds saturating hit/miss/write-back counters.
module dmem_cache_wb
  import dmem_cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned OFFSET_BITS   = 2,
  parameter int unsigned INDEX_BITS    = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
`ifdef DMEM_CACHE_PERF_COUNTERS_EN
  ,
  output logic [15:0]                          perf_hits,
  output logic [15:0]                          perf_misses,
  output logic [15:0]                          perf_writebacks
`endif
);

  localparam int unsigned NUM_CHUNKS = 2 ** OFFSET_BITS;
  localparam int unsigned NUM_LINES  = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned IDX_W      = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [OFFSET_BITS-1:0] LAST_CHUNK = OFFSET_BITS'(NUM_CHUNKS - 1);

  logic [ADDR_BITS-1:0] rd_addr_a [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] wr_addr_a [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] wr_data_a [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rd_data_d [NUM_CONSUMERS];

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_port
    assign rd_addr_a[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_a[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_a[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  // Line store: data words, tags, and per-line valid/dirty.
  logic [DATA_BITS-1:0] data_q [NUM_LINES][NUM_CHUNKS];
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, dirty_q;

  logic [STATE_BITS-1:0]    state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d, gnt_q, gnt_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [DATA_BITS-1:0]     wdata_q, wdata_d;
  logic                     is_wr_q, is_wr_d;
  logic [OFFSET_BITS-1:0]   chunk_q, chunk_d;
  logic [NUM_CONSUMERS-1:0] rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic                     mem_rv_q, mem_rv_d, mem_wv_q, mem_wv_d;
  logic [ADDR_BITS-1:0]     mem_ra_q, mem_ra_d, mem_wa_q, mem_wa_d;
  logic [DATA_BITS-1:0]     mem_wd_q, mem_wd_d;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   hit;

  assign req_tag = TAG_BITS'(get_tag(32'(addr_q), OFFSET_BITS, INDEX_BITS));
  assign req_idx = INDEX_BITS'(get_index(32'(addr_q), OFFSET_BITS, INDEX_BITS));
  assign req_off = OFFSET_BITS'(get_offset(32'(addr_q), OFFSET_BITS));
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  logic [NUM_CONSUMERS-1:0] gnt_oh_c;
  logic [IDX_W-1:0]         gnt_idx_c;
  logic                     gnt_vld_c;

  rr_arbiter #(.NUM_REQ(NUM_CONSUMERS), .IDX_W(IDX_W)) u_arb (
    .req_i       (consumer_read_valid | consumer_write_valid),
    .ptr_i       (ptr_q),
    .gnt_oh_c_o  (gnt_oh_c),
    .gnt_idx_c_o (gnt_idx_c),
    .gnt_vld_c_o (gnt_vld_c)
  );

  logic                   dwe, fill_done, dirty_set, dirty_clr, gnt_is_rd;
  logic [OFFSET_BITS-1:0] dwe_off;
  logic [DATA_BITS-1:0]   dwe_data;

  always_comb begin
    state_d   = state_q;   ptr_d    = ptr_q;    gnt_d   = gnt_q;
    addr_d    = addr_q;    wdata_d  = wdata_q;  is_wr_d = is_wr_q;
    chunk_d   = chunk_q;   rd_rdy_d = rd_rdy_q; wr_rdy_d = wr_rdy_q;
    rd_data_d = rd_data_q;
    mem_rv_d  = mem_rv_q;  mem_ra_d = mem_ra_q;
    mem_wv_d  = mem_wv_q;  mem_wa_d = mem_wa_q; mem_wd_d = mem_wd_q;
    dwe       = 1'b0;      dwe_off  = req_off;  dwe_data = wdata_q;
    fill_done = 1'b0;      dirty_set = 1'b0;    dirty_clr = 1'b0;
    gnt_is_rd = |(gnt_oh_c & consumer_read_valid);
    case (state_q)
      S_IDLE: if (gnt_vld_c) begin
        gnt_d   = gnt_idx_c;
        is_wr_d = !gnt_is_rd;
        addr_d  = gnt_is_rd ? rd_addr_a[gnt_idx_c] : wr_addr_a[gnt_idx_c];
        wdata_d = wr_data_a[gnt_idx_c];
        ptr_d   = IDX_W'((32'(gnt_idx_c) + 32'd1) % NUM_CONSUMERS);
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        chunk_d = '0;
        if (hit) begin
          if (is_wr_q) begin
            dwe             = 1'b1;
            dirty_set       = 1'b1;
            wr_rdy_d[gnt_q] = 1'b1;
          end else begin
            rd_rdy_d[gnt_q]  = 1'b1;
            rd_data_d[gnt_q] = data_q[req_idx][req_off];
          end
          state_d = S_RELAY;
        end else begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_EVICT : S_FILL;
        end
      end
      // Each word: raise valid, hold until accepted, then drop for one cycle.
      S_EVICT: if (mem_wv_q) begin
        if (mem_write_ready) begin
          mem_wv_d = 1'b0;
          if (chunk_q == LAST_CHUNK) begin
            dirty_clr = 1'b1;
            chunk_d   = '0;
            state_d   = S_FILL;
          end else begin
            chunk_d = chunk_q + OFFSET_BITS'(1);
          end
        end
      end else begin
        mem_wv_d = 1'b1;
        mem_wa_d = {tag_q[req_idx], req_idx, chunk_q};
        mem_wd_d = data_q[req_idx][chunk_q];
      end
      S_FILL: if (mem_rv_q) begin
        if (mem_read_ready) begin
          mem_rv_d = 1'b0;
          dwe      = 1'b1;
          dwe_off  = chunk_q;
          dwe_data = mem_read_data;
          if (chunk_q == LAST_CHUNK) begin
            fill_done = 1'b1;
            state_d   = S_LOOKUP;
          end else begin
            chunk_d = chunk_q + OFFSET_BITS'(1);
          end
        end
      end else begin
        mem_rv_d = 1'b1;
        mem_ra_d = {req_tag, req_idx, chunk_q};
      end
      S_RELAY: if (is_wr_q ? !consumer_write_valid[gnt_q] : !consumer_read_valid[gnt_q]) begin
        rd_rdy_d[gnt_q] = 1'b0;
        wr_rdy_d[gnt_q] = 1'b0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE; ptr_q   <= '0; gnt_q    <= '0; addr_q  <= '0;
      wdata_q  <= '0;     is_wr_q <= 1'b0; chunk_q <= '0;
      rd_rdy_q <= '0;     wr_rdy_q <= '0;
      for (int i = 0; i < int'(NUM_CONSUMERS); i++) rd_data_q[i] <= '0;
      mem_rv_q <= 1'b0;   mem_ra_q <= '0;
      mem_wv_q <= 1'b0;   mem_wa_q <= '0; mem_wd_q <= '0;
      valid_q  <= '0;     dirty_q  <= '0;
    end else begin
      state_q  <= state_d;  ptr_q   <= ptr_d;   gnt_q    <= gnt_d;   addr_q  <= addr_d;
      wdata_q  <= wdata_d;  is_wr_q <= is_wr_d; chunk_q  <= chunk_d;
      rd_rdy_q <= rd_rdy_d; wr_rdy_q <= wr_rdy_d; rd_data_q <= rd_data_d;
      mem_rv_q <= mem_rv_d; mem_ra_q <= mem_ra_d;
      mem_wv_q <= mem_wv_d; mem_wa_q <= mem_wa_d; mem_wd_q <= mem_wd_d;
      if (fill_done) valid_q[req_idx] <= 1'b1;
      if (dirty_set) dirty_q[req_idx] <= 1'b1;
      if (dirty_clr) dirty_q[req_idx] <= 1'b0;
    end
  end

  // Payload arrays need no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (dwe)       data_q[req_idx][dwe_off] <= dwe_data;
    if (fill_done) tag_q[req_idx]           <= req_tag;
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_write_ready = wr_rdy_q;
  assign mem_read_valid       = mem_rv_q;
  assign mem_read_address     = mem_ra_q;
  assign mem_write_valid      = mem_wv_q;
  assign mem_write_address    = mem_wa_q;
  assign mem_write_data       = mem_wd_q;

`ifdef DMEM_CACHE_PERF_COUNTERS_EN
  logic        post_fill_q;
  logic [15:0] hits_q, misses_q, wbs_q;

  // The LOOKUP right after a refill always hits and is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      post_fill_q <= 1'b0; hits_q <= '0; misses_q <= '0; wbs_q <= '0;
    end else begin
      post_fill_q <= fill_done;
      if (state_q == S_LOOKUP && hit && !post_fill_q && hits_q != 16'hFFFF)
        hits_q <= hits_q + 16'd1;
      if (state_q == S_LOOKUP && !hit && misses_q != 16'hFFFF)
        misses_q <= misses_q + 16'd1;
      if (dirty_clr && wbs_q != 16'hFFFF)
        wbs_q <= wbs_q + 16'd1;
    end
  end

  assign perf_hits       = hits_q;
  assign perf_misses     = misses_q;
  assign perf_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_dmem_cache_wb.sv
// Directed self-checking bench for dmem_cache_wb with a behavioural memory model.
module tb_dmem_cache_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rv, wv;
  logic [7:0]  ra [4];
  logic [7:0]  wa [4];
  logic [7:0]  wd [4];
  logic [3:0]  consumer_read_ready, consumer_write_ready;
  logic [31:0] consumer_read_data;
  logic        mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [7:0]  mem_read_address, mem_read_data, mem_write_address, mem_write_data;

  always #5 clk = ~clk;

  dmem_cache_wb dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  ({ra[3], ra[2], ra[1], ra[0]}),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (wv),
    .consumer_write_address ({wa[3], wa[2], wa[1], wa[0]}),
    .consumer_write_data    ({wd[3], wd[2], wd[1], wd[0]}),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: mem[a] = a ^ 0xB0, so 0x10..0x13 hold 0xA0..0xA3.
  logic [7:0]  mem [256];
  logic [16:0] ev_q [$];   // {is_write, addr, data}
  int rd_delay = 0, rd_cnt = 0, wr_acks_left = 1000;
  int stab_err = 0, both_err = 0;
  logic       stall_seen = 1'b0;
  logic [7:0] last_ra = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hB0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_read_valid && mem_write_valid) both_err++;
      if (mem_read_ready) begin
        mem_read_ready = 1'b0;
        rd_cnt = 0;
      end else if (mem_read_valid) begin
        if (stall_seen && mem_read_address != last_ra) stab_err++;
        if (rd_cnt >= rd_delay) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[mem_read_address];
          ev_q.push_back({1'b0, mem_read_address, mem[mem_read_address]});
          stall_seen = 1'b0;
        end else begin
          rd_cnt++;
          stall_seen = 1'b1;
          last_ra = mem_read_address;
        end
      end else if (stall_seen) begin
        stab_err++;
        stall_seen = 1'b0;
      end
      if (mem_write_ready) begin
        mem_write_ready = 1'b0;
      end else if (mem_write_valid && wr_acks_left > 0) begin
        wr_acks_left--;
        mem[mem_write_address] = mem_write_data;
        ev_q.push_back({1'b1, mem_write_address, mem_write_data});
        mem_write_ready = 1'b1;
      end
    end
  end

  task automatic rd_txn(input int p, input logic [7:0] a, output logic [7:0] d, output int lat);
    int n = 0;
    rv[p] = 1'b1; ra[p] = a; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!consumer_read_ready[p] && lat < 300);
    if (!consumer_read_ready[p]) chk("rd_timeout", 32'(consumer_read_ready[p]), 32'd1);
    d = consumer_read_data[p*8 +: 8];
    rv[p] = 1'b0;
    do begin @(posedge clk); #1; n++; end while (consumer_read_ready[p] && n < 20);
  endtask

  task automatic wr_txn(input int p, input logic [7:0] a, input logic [7:0] dat, output int lat);
    int n = 0;
    wv[p] = 1'b1; wa[p] = a; wd[p] = dat; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!consumer_write_ready[p] && lat < 300);
    if (!consumer_write_ready[p]) chk("wr_timeout", 32'(consumer_write_ready[p]), 32'd1);
    wv[p] = 1'b0;
    do begin @(posedge clk); #1; n++; end while (consumer_write_ready[p] && n < 20);
  endtask

  function automatic logic outs_any();
    return |{consumer_read_ready, consumer_write_ready, consumer_read_data, mem_read_valid,
             mem_read_address, mem_write_valid, mem_write_address, mem_write_data};
  endfunction

  logic [7:0]  d;
  int          lat;
  logic [14:0] order;
  int          n_gnt, cyc, nwr;
  logic        re_done;

  initial begin
    rv = '0; wv = '0;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs_zero", 32'(outs_any()), 32'd0);
    reset = 1'b0;

    // Cold read miss: clean line fill of 0x10..0x13.
    ev_q.delete();
    rd_txn(0, 8'h12, d, lat);
    chk("cold_rd_data", 32'(d), 32'hA2);
    chk("cold_rd_latency", 32'(lat), 32'd11);
    chk("cold_ev_count", 32'(ev_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ev_q.size(); i++)
      chk("cold_fill_ev", 32'(ev_q[i]), {15'd0, 1'b0, 8'h10 + 8'(i), 8'hA0 + 8'(i)});

    ev_q.delete();
    rd_txn(0, 8'h13, d, lat);
    chk("hit_rd_data", 32'(d), 32'hA3);
    chk("hit_rd_latency", 32'(lat), 32'd2);
    chk("hit_no_mem", 32'(ev_q.size()), 32'd0);

    // Write hit dirties the line without memory traffic.
    wr_txn(0, 8'h11, 8'h55, lat);
    chk("wr_hit_latency", 32'(lat), 32'd2);
    chk("wr_hit_no_mem", 32'(ev_q.size()), 32'd0);

    // Conflicting tag at index 4: write-back then refill.
    rd_txn(0, 8'h31, d, lat);
    chk("evict_rd_data", 32'(d), 32'h81);
    chk("evict_latency", 32'(lat), 32'd19);
    chk("evict_ev_count", 32'(ev_q.size()), 32'd8);
    if (ev_q.size() == 8) begin
      chk("evict_wr0", 32'(ev_q[0]), {15'd0, 1'b1, 8'h10, 8'hA0});
      chk("evict_wr1", 32'(ev_q[1]), {15'd0, 1'b1, 8'h11, 8'h55});
      chk("evict_wr2", 32'(ev_q[2]), {15'd0, 1'b1, 8'h12, 8'hA2});
      chk("evict_wr3", 32'(ev_q[3]), {15'd0, 1'b1, 8'h13, 8'hA3});
      for (int i = 0; i < 4; i++)
        chk("evict_refill", 32'(ev_q[4+i]), {15'd0, 1'b0, 8'h30 + 8'(i), 8'h80 + 8'(i)});
    end

    // Write miss allocates with a clean fill.
    ev_q.delete();
    wr_txn(2, 8'h48, 8'h77, lat);
    chk("wr_miss_latency", 32'(lat), 32'd11);
    chk("wr_miss_ev_count", 32'(ev_q.size()), 32'd4);
    if (ev_q.size() > 0) chk("wr_miss_first_fill", 32'(ev_q[0]), {15'd0, 1'b0, 8'h48, 8'hF8});
    ev_q.delete();
    rd_txn(3, 8'h48, d, lat);
    chk("wr_alloc_readback", 32'(d), 32'h77);
    chk("wr_alloc_rd_latency", 32'(lat), 32'd2);
    chk("other_port_holds", 32'(consumer_read_data[7:0]), 32'h81);

    // Round robin: all four request together, port 1 re-requests right after service.
    ev_q.delete();
    ra[0] = 8'h30; ra[1] = 8'h48; ra[2] = 8'h31; ra[3] = 8'h4A;
    rv = 4'hF; order = '0; n_gnt = 0; cyc = 0; re_done = 1'b0;
    while (n_gnt < 5 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      for (int p = 0; p < 4; p++) begin
        if (rv[p] && consumer_read_ready[p]) begin
          order = {order[11:0], 3'(p)};
          n_gnt++;
          case (p)
            0: chk("rr_data0", 32'(consumer_read_data[7:0]), 32'h80);
            1: chk("rr_data1", 32'(consumer_read_data[15:8]), 32'h77);
            2: chk("rr_data2", 32'(consumer_read_data[23:16]), 32'h81);
            default: chk("rr_data3", 32'(consumer_read_data[31:24]), 32'hFA);
          endcase
          rv[p] = 1'b0;
        end
      end
      if (!re_done && !rv[1] && !consumer_read_ready[1] && n_gnt == 2) begin
        rv[1] = 1'b1; re_done = 1'b1;
      end
    end
    rv = '0;
    repeat (3) @(posedge clk);
    #1 chk("rr_order", 32'(order), {17'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1});
    chk("rr_no_mem", 32'(ev_q.size()), 32'd0);

    // Memory backpressure: 5-cycle delay per read word.
    rd_delay = 5; stab_err = 0;
    rd_txn(0, 8'h60, d, lat);
    chk("bp_rd_data", 32'(d), 32'hD0);
    chk("bp_latency", 32'(lat), 32'd31);
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_ev_count", 32'(ev_q.size()), 32'd4);
    rd_delay = 0;

    // Reset during the second word of a write-back.
    wr_txn(0, 8'h61, 8'h99, lat);
    chk("dirty_wr_latency", 32'(lat), 32'd2);
    ev_q.delete();
    wr_acks_left = 1;
    rv[0] = 1'b1; ra[0] = 8'h81; cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      nwr = 0;
      foreach (ev_q[i]) if (ev_q[i][16]) nwr++;
    end while (!(mem_write_valid && nwr == 1) && cyc < 200);
    chk("evict_second_word_seen", 32'(mem_write_valid), 32'd1);
    chk("evict_addr_second", 32'(mem_write_address), 32'h61);
    reset = 1'b1; rv[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_evict_reset_zero", 32'(outs_any()), 32'd0);
    reset = 1'b0; wr_acks_left = 1000;
    chk("mid_evict_ev_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() > 0) chk("mid_evict_first_wr", 32'(ev_q[0]), {15'd0, 1'b1, 8'h60, 8'hD0});

    ev_q.delete();
    rd_txn(0, 8'h30, d, lat);
    chk("post_rst_refetch_lat", 32'(lat), 32'd11);
    chk("post_rst_refetch_data", 32'(d), 32'h80);
    ev_q.delete();
    rd_txn(1, 8'h10, d, lat);
    chk("post_rst_rd10_data", 32'(d), 32'hA0);
    chk("post_rst_rd10_ev", 32'(ev_q.size()), 32'd4);

    chk("rd_wr_never_both", 32'(both_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
